// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys
// generated on the fly from K16 down to K1 by right-rotating C/D.
// S-box lookups live in sbox1..sbox8; index row = {b1,b6}, column = b2..b5.

module sbox1 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox2 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox3 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox4 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox5 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox6 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox7 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module sbox8 (input logic [5:0] i_b, output logic [3:0] o_s);
  localparam logic [0:63][3:0] T = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  assign o_s = T[{i_b[5], i_b[0], i_b[4:1]}];
endmodule

module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [63:0] ciphertext,
  output logic        ready,
  output logic        done,
  output logic [63:0] plaintext
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  // FIPS tables, entries are 1-based source bit numbers with bit 1 = MSB.
  localparam int unsigned IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int unsigned FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                        34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int unsigned E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int unsigned P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                        2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int unsigned PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                         10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                         63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                         14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int unsigned PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                         41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  state_t      r_state;
  logic [3:0]  r_rnd;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic        r_ready, r_done;
  logic [63:0] r_pt;

  logic [27:0] w_c, w_d;
  logic [47:0] w_k, w_x;
  logic [31:0] w_s, w_f, w_rn;
  logic [63:0] w_ip;
  logic [55:0] w_pc1;

  // Rotate C/D right ahead of the round (none for round 1, 1 bit before rounds 2/9/16).
  always_comb begin
    w_c = r_c;
    w_d = r_d;
    if (r_rnd == 4'd1 || r_rnd == 4'd8 || r_rnd == 4'd15) begin
      w_c = {r_c[0], r_c[27:1]};
      w_d = {r_d[0], r_d[27:1]};
    end else if (r_rnd != 4'd0) begin
      w_c = {r_c[1:0], r_c[27:2]};
      w_d = {r_d[1:0], r_d[27:2]};
    end
  end

  assign w_k   = f_pc2({w_c, w_d});
  assign w_x   = f_e(r_r) ^ w_k;
  assign w_f   = f_p(w_s);
  assign w_rn  = r_l ^ w_f;
  assign w_ip  = f_ip(ciphertext);
  assign w_pc1 = f_pc1(key);

  sbox1 u_sbox1 (.i_b(w_x[47:42]), .o_s(w_s[31:28]));
  sbox2 u_sbox2 (.i_b(w_x[41:36]), .o_s(w_s[27:24]));
  sbox3 u_sbox3 (.i_b(w_x[35:30]), .o_s(w_s[23:20]));
  sbox4 u_sbox4 (.i_b(w_x[29:24]), .o_s(w_s[19:16]));
  sbox5 u_sbox5 (.i_b(w_x[23:18]), .o_s(w_s[15:12]));
  sbox6 u_sbox6 (.i_b(w_x[17:12]), .o_s(w_s[11:8]));
  sbox7 u_sbox7 (.i_b(w_x[11:6]),  .o_s(w_s[7:4]));
  sbox8 u_sbox8 (.i_b(w_x[5:0]),   .o_s(w_s[3:0]));

  // Control FSM and datapath: load on accepted start, one round per edge, result on round 16.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_pt    <= '0;
      r_rnd   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_c     <= w_pc1[55:28];
            r_d     <= w_pc1[27:0];
            r_rnd   <= '0;
            r_state <= S_ROUND;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_ROUND: begin
          r_l   <= r_r;
          r_r   <= w_rn;
          r_c   <= w_c;
          r_d   <= w_d;
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'd15) begin
            // Halves are swapped ({R16,L16}) before the final permutation.
            r_pt    <= f_fp({w_rn, r_r});
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign plaintext = r_pt;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Testbench for des_decrypt_iter: known answers, back-to-back, busy-ignore,
// mid-operation reset and a round trip against a behavioural DES encryptor.
`timescale 1ns/1ps

module tb_des_decrypt_iter;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] key, ciphertext;
  logic        ready, done;
  logic [63:0] plaintext;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K2P = 64'h0F339333EB6C0C72;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;

  des_decrypt_iter dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .ciphertext(ciphertext),
    .ready(ready), .done(done), .plaintext(plaintext)
  );

  always #5 clk = ~clk;

  // Behavioural DES encryption (left-rotating key schedule, precomputed per round).
  int unsigned IP_T[$]  = {58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                           64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                           61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int unsigned FP_T[$]  = {40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                           37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                           34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int unsigned E_T[$]   = {32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                           16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int unsigned P_T[$]   = {16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,
                           19,13,30,6,22,11,4,25};
  int unsigned PC1_T[$] = {57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                           60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                           29,21,13,5,28,20,12,4};
  int unsigned PC2_T[$] = {14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                           41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int unsigned SHIFTS[$] = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  function automatic logic [63:0] perm(input logic [63:0] x, input int unsigned iw, input int unsigned t[$]);
    logic [63:0] y;
    int unsigned ow;
    y  = '0;
    ow = t.size();
    for (int unsigned i = 0; i < ow; i++) y[6'(ow - 1 - i)] = x[6'(iw - t[i])];
    return y;
  endfunction

  function automatic logic [3:0] sb(input int unsigned k, input logic [5:0] b);
    logic [255:0] row;
    int unsigned  idx;
    row = SB[3'(k)];
    idx = 32'({b[5], b[0], b[4:1]});
    return row[8'(255 - 4 * idx) -: 4];
  endfunction

  function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    t = perm({32'b0, r}, 32, E_T);
    x = t[47:0] ^ k;
    s = '0;
    for (int unsigned j = 0; j < 8; j++) s[5'(31 - 4 * j) -: 4] = sb(j, x[6'(47 - 6 * j) -: 6]);
    t = perm({32'b0, s}, 32, P_T);
    return t[31:0];
  endfunction

  function automatic logic [63:0] des_enc(input logic [63:0] k, input logic [63:0] p);
    logic [63:0] t;
    logic [27:0] c, d;
    logic [31:0] l, r, nr;
    t = perm(k, 64, PC1_T); c = t[55:28]; d = t[27:0];
    t = perm(p, 64, IP_T);  l = t[63:32]; r = t[31:0];
    for (int unsigned i = 0; i < 16; i++) begin
      for (int unsigned s = 0; s < SHIFTS[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t  = perm({8'b0, c, d}, 56, PC2_T);
      nr = l ^ ffun(r, t[47:0]);
      l  = r;
      r  = nr;
    end
    return perm({r, l}, 64, FP_T);
  endfunction

  // Steps negedges until done is seen or the limit expires; no checking here.
  task automatic wait_done(input int unsigned limit, output int unsigned n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key = K1; ciphertext = C1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (plaintext !== 64'h0) begin n_bad++; $display("FAIL reset_pt: got %h want 0", plaintext); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_kat1();
    int unsigned n;
    bit seen;
    logic [63:0] e;
    key = K1; ciphertext = C1; start = 1'b1;
    exp_q.push_back(P1);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) begin key = {$urandom, $urandom}; ciphertext = {$urandom, $urandom}; end
      if (done) seen = 1'b1;
      else if (n <= 16) begin
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL kat1_busy_ready cyc%0d: got %b want 0", n, ready); end
      end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL kat1_timeout: got no done want done"); void'(exp_q.pop_front()); end
    else begin
      e = exp_q.pop_front();
      if (plaintext !== e) begin n_bad++; $display("FAIL kat1_pt: got %h want %h", plaintext, e); end
      n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL kat1_latency: got %0d want 17", n); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL kat1_done_ready: got %b want 1", ready); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL kat1_pulse: got %b want 0", done); end
  endtask

  task automatic test_kat2();
    int unsigned n;
    bit seen;
    logic [63:0] e;
    logic [63:0] keys [2];
    keys[0] = K2; keys[1] = K2P;
    for (int unsigned j = 0; j < 2; j++) begin
      key = keys[j]; ciphertext = C2; start = 1'b1;
      exp_q.push_back(P2);
      wait_done(40, n, seen);
      n_cmp++;
      e = exp_q.pop_front();
      if (!seen) begin n_bad++; $display("FAIL kat2_timeout key%0d: got no done want done", j); end
      else if (plaintext !== e) begin n_bad++; $display("FAIL kat2_pt key%0d: got %h want %h", j, plaintext, e); end
      n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL kat2_latency key%0d: got %0d want 17", j, n); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n, ndone, last;
    logic [63:0] e;
    key = K1; ciphertext = C1; start = 1'b1;
    exp_q.push_back(P1);
    n = 0; ndone = 0; last = 0;
    while (ndone < 2 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        ndone++;
        e = exp_q.pop_front();
        n_cmp++; if (plaintext !== e) begin n_bad++; $display("FAIL b2b_pt%0d: got %h want %h", ndone, plaintext, e); end
        n_cmp++; if (n - last !== 17) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 17", ndone, n - last); end
        if (ndone == 1) begin
          key = K2; ciphertext = C2;
          exp_q.push_back(P2);
        end else start = 1'b0;
        last = n;
      end else if (ndone == 1 && n == last + 8) begin
        n_cmp++; if (plaintext !== P1) begin n_bad++; $display("FAIL b2b_hold: got %h want %h", plaintext, P1); end
      end
    end
    n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_timeout: got %0d dones want 2", ndone); end
    start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got done=%b ready=%b want done=0 ready=1", done, ready); end
  endtask

  task automatic test_busy_ignore();
    int unsigned n, extra;
    bit seen;
    logic [63:0] e;
    key = K1; ciphertext = C1; start = 1'b1;
    exp_q.push_back(P1);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      start = (n == 3 || n == 10);
      if (start) ciphertext = {$urandom, $urandom};
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    n_cmp++;
    e = exp_q.pop_front();
    if (!seen) begin n_bad++; $display("FAIL busy_timeout: got no done want done"); end
    else if (plaintext !== e) begin n_bad++; $display("FAIL busy_pt: got %h want %h", plaintext, e); end
    n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL busy_latency: got %0d want 17", n); end
    extra = 0;
    repeat (20) begin @(negedge clk); if (done) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int unsigned n, extra;
    bit seen;
    logic [63:0] e;
    key = K1; ciphertext = C1; start = 1'b1;
    repeat (8) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_cmp++; if (plaintext !== 64'h0) begin n_bad++; $display("FAIL rstmid_pt: got %h want 0", plaintext); end
    extra = 0;
    repeat (25) begin @(negedge clk); if (done) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", extra); end
    key = K2; ciphertext = C2; start = 1'b1;
    exp_q.push_back(P2);
    wait_done(40, n, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL rstmid_timeout: got no done want done"); end
    else if (plaintext !== e) begin n_bad++; $display("FAIL rstmid_pt2: got %h want %h", plaintext, e); end
    n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL rstmid_latency: got %0d want 17", n); end
    @(negedge clk);
  endtask

  task automatic test_roundtrip();
    int unsigned n;
    bit seen;
    logic [63:0] k, p, e;
    for (int unsigned it = 0; it < 200; it++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      key = k; ciphertext = des_enc(k, p); start = 1'b1;
      exp_q.push_back(p);
      wait_done(40, n, seen);
      e = exp_q.pop_front();
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rt_timeout it%0d: got no done want done", it); end
      else if (plaintext !== e) begin n_bad++; $display("FAIL rt_pt it%0d: got %h want %h", it, plaintext, e); end
      n_cmp++; if (n !== 17) begin n_bad++; $display("FAIL rt_latency it%0d: got %0d want 17", it, n); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    @(negedge clk);
    test_reset();
    test_kat1();
    test_kat2();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_roundtrip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
